// File: rtl/mips32_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// mips32_hazard_ctrl
//   Register-scoreboard interlock for the no-forwarding pipe_MIPS32 core.
//   Each architectural register has a small down-counter that is loaded when
//   a writer issues out of ID and reaches zero when the value is readable by
//   ID again. A reader of a busy register is held in ID (stall) and a NOP is
//   fed into EX (bubble). A HLT instruction drains the outstanding writes and
//   then parks the core in HALT until reset.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   id_valid            instruction present in ID
//   id_rs/_used         source 1 index and "is read" flag
//   id_rt/_used         source 2 index and "is read" flag
//   id_wr_en, id_rd     instruction writes register id_rd
//   id_halt             instruction is HLT
//   flush               taken branch kills the ID instruction this cycle
//   stall               hold PC and IF/ID latch
//   issue               ID instruction advances to EX this cycle
//   bubble              inject NOP into EX this cycle
//   drained             no pending register writes
//   halted              core halted (sticky until rst)
//   stall_cnt           saturating count of cycles with stall=1
//   dbg_state           current FSM state (RUN=0, DRAIN=1, HALT=2)
//
// Handshake: issue is the ID->EX transfer strobe. It is asserted only when
// id_valid=1 and the instruction is neither killed (flush) nor blocked
// (hazard, DRAIN/HALT). Whenever id_valid=1 and issue=0, bubble=1; stall=1
// additionally tells the front end to hold the instruction for a retry.
// ---------------------------------------------------------------------------
module mips32_hazard_ctrl #(
  parameter int NREG   = 32,
  parameter int AW     = 5,
  parameter int WB_LAT = 3
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          id_valid,
  input  logic [AW-1:0] id_rs,
  input  logic          id_rs_used,
  input  logic [AW-1:0] id_rt,
  input  logic          id_rt_used,
  input  logic          id_wr_en,
  input  logic [AW-1:0] id_rd,
  input  logic          id_halt,
  input  logic          flush,
  output logic          stall,
  output logic          issue,
  output logic          bubble,
  output logic          drained,
  output logic          halted,
  output logic [15:0]   stall_cnt,
  output logic [1:0]    dbg_state
);

  localparam int CW = $clog2(WB_LAT + 1);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q [NREG];
  logic [CW-1:0]   cnt_d [NREG];
  logic [15:0]     stall_cnt_q, stall_cnt_d;
  logic            hazard;
  logic            any_busy;

  // Hazard looks only at this cycle's counters: a writer issuing in the same
  // cycle cannot collide because issue is one instruction per cycle.
  always_comb begin
    hazard = (id_rs_used && (id_rs != '0) && (cnt_q[id_rs] != '0)) ||
             (id_rt_used && (id_rt != '0) && (cnt_q[id_rt] != '0));
  end

  always_comb begin
    any_busy = 1'b0;
    for (int r = 0; r < NREG; r++) begin
      any_busy = any_busy | (|cnt_q[r]);
    end
  end

  // FSM next state and handshake outputs.
  always_comb begin
    state_d = state_q;
    issue   = 1'b0;
    stall   = 1'b0;
    bubble  = 1'b0;
    halted  = 1'b0;
    drained = ~any_busy;
    unique case (state_q)
      ST_RUN: begin
        issue  = id_valid & ~flush & ~hazard;
        stall  = id_valid & ~flush & hazard;
        bubble = id_valid & ~issue;
        if (issue && id_halt) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        stall  = id_valid;
        bubble = id_valid;
        // halted rises in the same cycle the last write retires.
        if (drained) begin
          state_d = ST_HALT;
          halted  = 1'b1;
        end
      end
      ST_HALT: begin
        stall  = id_valid;
        bubble = id_valid;
        halted = 1'b1;
      end
      default: state_d = ST_RUN;
    endcase
    // While rst is asserted the outputs already show their reset values.
    if (rst) begin
      state_d = ST_RUN;
      issue   = 1'b0;
      stall   = 1'b0;
      bubble  = 1'b0;
      halted  = 1'b0;
      drained = 1'b1;
    end
  end

  // Scoreboard: decrement every busy counter, reload on a writing issue.
  always_comb begin
    for (int r = 0; r < NREG; r++) begin
      cnt_d[r] = (cnt_q[r] != '0) ? cnt_q[r] - CW'(1) : '0;
      if (r != 0 && issue && id_wr_en && !id_halt && id_rd == AW'(r)) begin
        cnt_d[r] = CW'(WB_LAT);
      end
    end
    cnt_d[0] = '0;
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall && stall_cnt_q != 16'hFFFF) stall_cnt_d = stall_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      stall_cnt_q <= '0;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
    end else begin
      state_q     <= state_d;
      stall_cnt_q <= stall_cnt_d;
      for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mips32_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_mips32_hazard_ctrl
//   Directed scenarios for the scoreboard interlock: back-to-back RAW,
//   independent filler, R0 writes, flush of a stalled consumer, HLT drain and
//   halt, reset mid-dependency. Inputs change 1 ns after the rising edge and
//   outputs are sampled 2 ns later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_mips32_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [4:0]  id_rs;
  logic        id_rs_used;
  logic [4:0]  id_rt;
  logic        id_rt_used;
  logic        id_wr_en;
  logic [4:0]  id_rd;
  logic        id_halt;
  logic        flush;
  logic        stall;
  logic        issue;
  logic        bubble;
  logic        drained;
  logic        halted;
  logic [15:0] stall_cnt;
  logic [1:0]  dbg_state;

  int tests_run    = 0;
  int tests_failed = 0;

  // Expected {stall, issue} per cycle for the RAW sequence.
  logic [1:0] exp_q[$];

  mips32_hazard_ctrl #(.NREG(32), .AW(5), .WB_LAT(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rs_used (id_rs_used),
    .id_rt      (id_rt),
    .id_rt_used (id_rt_used),
    .id_wr_en   (id_wr_en),
    .id_rd      (id_rd),
    .id_halt    (id_halt),
    .flush      (flush),
    .stall      (stall),
    .issue      (issue),
    .bubble     (bubble),
    .drained    (drained),
    .halted     (halted),
    .stall_cnt  (stall_cnt),
    .dbg_state  (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_id(input logic v, input logic [4:0] rs, input logic rs_u,
                          input logic [4:0] rt, input logic rt_u, input logic wr,
                          input logic [4:0] rd, input logic hlt, input logic fl);
    id_valid   = v;
    id_rs      = rs;
    id_rs_used = rs_u;
    id_rt      = rt;
    id_rt_used = rt_u;
    id_wr_en   = wr;
    id_rd      = rd;
    id_halt    = hlt;
    flush      = fl;
  endtask

  task automatic drive_idle();
    drive_id(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
  endtask

  // ADD rd, rs, rt
  task automatic drive_add(input logic [4:0] rd, input logic [4:0] rs, input logic [4:0] rt);
    drive_id(1'b1, rs, 1'b1, rt, 1'b1, 1'b1, rd, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    drive_idle();
    tick();
    tick();
    rst = 1'b0;
  endtask

  // ---------------- checker ----------------
  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst = 1'b1;
    drive_idle();
    tick();

    // Outputs during reset and right after release.
    settle();
    check("rst_issue", 16'(issue), 16'd0);
    check("rst_drained", 16'(drained), 16'd1);
    tick();
    rst = 1'b0;
    settle();
    check("post_rst_stall", 16'(stall), 16'd0);
    check("post_rst_issue", 16'(issue), 16'd0);
    check("post_rst_bubble", 16'(bubble), 16'd0);
    check("post_rst_halted", 16'(halted), 16'd0);
    check("post_rst_drained", 16'(drained), 16'd1);
    check("post_rst_stall_cnt", stall_cnt, 16'd0);
    check("post_rst_state", 16'(dbg_state), 16'd0);
    tick();

    // 1: ADD R4,R1,R2 ; ADD R5,R4,R3
    drive_add(5'd4, 5'd1, 5'd2);
    settle();
    check("t1_prod_issue", 16'(issue), 16'd1);
    check("t1_prod_stall", 16'(stall), 16'd0);
    tick();
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b01);
    drive_add(5'd5, 5'd4, 5'd3);
    for (int i = 0; i < 4; i++) begin
      logic [1:0] e;
      settle();
      e = exp_q.pop_front();
      check($sformatf("t1_cons_stall_issue_%0d", i), 16'({stall, issue}), 16'(e));
      check($sformatf("t1_cons_bubble_%0d", i), 16'(bubble), 16'(e[1]));
      if (i == 3) check("t1_stall_cnt", stall_cnt, 16'd3);
      tick();
    end
    drive_idle();
    settle();
    check("t1_r5_busy", 16'(drained), 16'd0);
    check("t1_idle_bubble", 16'(bubble), 16'd0);
    tick(); tick(); tick();
    settle();
    check("t1_drained_after", 16'(drained), 16'd1);

    // 2: ADD R4 ; OR R7,R7,R7 ; ADD R5,R4,R3
    do_reset();
    drive_add(5'd4, 5'd1, 5'd2);
    settle();
    check("t2_prod_issue", 16'(issue), 16'd1);
    tick();
    drive_add(5'd7, 5'd7, 5'd7);
    settle();
    check("t2_or_issue", 16'(issue), 16'd1);
    tick();
    drive_add(5'd5, 5'd4, 5'd3);
    settle();
    check("t2_stall_t2", 16'(stall), 16'd1);
    tick();
    settle();
    check("t2_stall_t3", 16'(stall), 16'd1);
    tick();
    settle();
    check("t2_issue_t4", 16'(issue), 16'd1);
    check("t2_stall_t4", 16'(stall), 16'd0);
    check("t2_stall_cnt", stall_cnt, 16'd2);
    tick();

    // 3: ADDI R0,R0,10 ; ADD R5,R0,R3
    do_reset();
    drive_id(1'b1, 5'd0, 1'b1, 5'd0, 1'b0, 1'b1, 5'd0, 1'b0, 1'b0);
    settle();
    check("t3_addi_issue", 16'(issue), 16'd1);
    tick();
    drive_add(5'd5, 5'd0, 5'd3);
    settle();
    check("t3_r0_drained", 16'(drained), 16'd1);
    check("t3_cons_issue", 16'(issue), 16'd1);
    check("t3_cons_stall", 16'(stall), 16'd0);
    tick();

    // 4: stalled consumer flushed at t+2; R4 then probed by a non-writer.
    do_reset();
    drive_add(5'd4, 5'd1, 5'd2);
    tick();
    drive_add(5'd5, 5'd4, 5'd3);
    settle();
    check("t4_stall_t1", 16'(stall), 16'd1);
    tick();
    flush = 1'b1;
    settle();
    check("t4_flush_issue", 16'(issue), 16'd0);
    check("t4_flush_stall", 16'(stall), 16'd0);
    check("t4_flush_bubble", 16'(bubble), 16'd1);
    tick();
    drive_id(1'b1, 5'd4, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    settle();
    check("t4_r4_busy_t3", 16'(stall), 16'd1);
    check("t4_drained_t3", 16'(drained), 16'd0);
    tick();
    settle();
    check("t4_r4_free_t4", 16'(issue), 16'd1);
    check("t4_drained_t4", 16'(drained), 16'd1);
    check("t4_stall_cnt", stall_cnt, 16'd2);
    tick();

    // 5: ADD R4 ; HLT -> DRAIN -> HALT, then reset back to RUN.
    do_reset();
    drive_add(5'd4, 5'd1, 5'd2);
    tick();
    drive_id(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd9, 1'b1, 1'b0);
    settle();
    check("t5_hlt_issue", 16'(issue), 16'd1);
    tick();
    drive_add(5'd6, 5'd1, 5'd2);
    settle();
    check("t5_drain_state", 16'(dbg_state), 16'd1);
    check("t5_drain_issue", 16'(issue), 16'd0);
    check("t5_drain_stall", 16'(stall), 16'd1);
    check("t5_halted_t2", 16'(halted), 16'd0);
    check("t5_r9_not_busy", 16'(drained), 16'd0);
    tick();
    flush = 1'b1;
    settle();
    check("t5_drain_flush_stall", 16'(stall), 16'd1);
    check("t5_halted_t3", 16'(halted), 16'd0);
    tick();
    flush = 1'b0;
    settle();
    check("t5_halted_t4", 16'(halted), 16'd1);
    check("t5_drained_t4", 16'(drained), 16'd1);
    for (int i = 0; i < 3; i++) begin
      tick();
      settle();
      check($sformatf("t5_halt_hold_%0d", i), 16'({halted, stall, issue}), 16'b110);
    end
    check("t5_halt_state", 16'(dbg_state), 16'd2);
    tick();
    rst = 1'b1;
    settle();
    check("t5_rst_halted", 16'(halted), 16'd0);
    tick();
    rst = 1'b0;
    settle();
    check("t5_run_issue", 16'(issue), 16'd1);
    check("t5_run_halted", 16'(halted), 16'd0);
    check("t5_run_stall_cnt", stall_cnt, 16'd0);
    tick();

    // 6: ADD R4 ; rst ; ADD R5,R4,R3 sees an empty scoreboard.
    do_reset();
    drive_add(5'd4, 5'd1, 5'd2);
    tick();
    rst = 1'b1;
    drive_idle();
    tick();
    rst = 1'b0;
    drive_add(5'd5, 5'd4, 5'd3);
    settle();
    check("t6_issue", 16'(issue), 16'd1);
    check("t6_stall", 16'(stall), 16'd0);
    check("t6_stall_cnt", stall_cnt, 16'd0);
    tick();
    drive_idle();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
